// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin priority and a registered write port.
// Optional REGFILE_ZERO_FILTER_EN: accepted writes to register 0 are granted but never pulse RegWr.
module regfile_write_arbiter (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        AReq,
    input  logic [4:0]  ARW,
    input  logic [31:0] ABusW,
    output logic        AGnt,
    input  logic        BReq,
    input  logic [4:0]  BRW,
    input  logic [31:0] BBusW,
    output logic        BGnt,
    output logic [4:0]  RW,
    output logic [31:0] BusW,
    output logic        RegWr,
    output logic [31:0] Busy,
    output logic [15:0] WrCnt
);
    localparam int unsigned AddrW   = 5;
    localparam int unsigned DataW   = 32;
    localparam int unsigned CntW    = 16;
    localparam int unsigned NumRegs = 32;

    typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} priState_t;

    priState_t          priState;
    priState_t          priNext;
    logic [AddrW-1:0]   selRW;
    logic [DataW-1:0]   selBusW;
    logic               anyGnt;
    logic               wrValid;

    // Grant selection, payload mux and pointer update; no grants while reset is asserted.
    always_comb begin
        priNext = priState;
        AGnt    = 1'b0;
        BGnt    = 1'b0;
        selRW   = ARW;
        selBusW = ABusW;
        if (Resetn) begin
            if (AReq && (!BReq || priState == PRI_A)) begin
                AGnt = 1'b1;
            end else if (BReq) begin
                BGnt = 1'b1;
            end
        end
        if (BGnt) begin
            selRW   = BRW;
            selBusW = BBusW;
        end
        if (AGnt) begin
            priNext = PRI_B;
        end else if (BGnt) begin
            priNext = PRI_A;
        end
        anyGnt = AGnt | BGnt;
`ifdef REGFILE_ZERO_FILTER_EN
        wrValid = anyGnt && (selRW != '0);
`else
        wrValid = anyGnt;
`endif
    end

    // Output stage: payload held between grants, RegWr/Busy reflect only the accepted cycle.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            priState <= PRI_A;
            RW       <= '0;
            BusW     <= '0;
            RegWr    <= 1'b0;
            Busy     <= '0;
            WrCnt    <= '0;
        end else begin
            priState <= priNext;
            if (anyGnt) begin
                RW   <= selRW;
                BusW <= selBusW;
            end
            RegWr <= wrValid;
            Busy  <= wrValid ? (NumRegs'(1) << selRW) : '0;
            if (RegWr) begin
                WrCnt <= WrCnt + CntW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a pointer model predicts grants and queues expected writes.
module tb_regfile_write_arbiter;
    logic        Clk;
    logic        Resetn;
    logic        AReq;
    logic [4:0]  ARW;
    logic [31:0] ABusW;
    logic        AGnt;
    logic        BReq;
    logic [4:0]  BRW;
    logic [31:0] BBusW;
    logic        BGnt;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic        RegWr;
    logic [31:0] Busy;
    logic [15:0] WrCnt;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] data;
    } wrExp_t;

    wrExp_t      expQ[$];
    int          testCnt = 0;
    int          failCnt = 0;
    logic        mPriB   = 1'b0;
    logic        mCurWr  = 1'b0;
    logic [15:0] mCnt    = '0;
    logic [4:0]  lastRw  = '0;
    logic [31:0] lastBus = '0;
    logic [31:0] rf [32];
`ifdef REGFILE_ZERO_FILTER_EN
    localparam bit FilterZero = 1'b1;
`else
    localparam bit FilterZero = 1'b0;
`endif

    regfile_write_arbiter dut (
        .Clk(Clk), .Resetn(Resetn),
        .AReq(AReq), .ARW(ARW), .ABusW(ABusW), .AGnt(AGnt),
        .BReq(BReq), .BRW(BRW), .BBusW(BBusW), .BGnt(BGnt),
        .RW(RW), .BusW(BusW), .RegWr(RegWr), .Busy(Busy), .WrCnt(WrCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file fed by the write port; $0 is hardwired to zero.
    always_ff @(posedge Clk) begin
        if (RegWr && RW != 5'd0) rf[RW] <= BusW;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive, check grants mid-cycle, update model, then check the output stage.
    task automatic step(input logic rstn,
                        input logic aReq, input logic [4:0] aRw, input logic [31:0] aBus,
                        input logic bReq, input logic [4:0] bRw, input logic [31:0] bBus);
        logic        expA, expB;
        logic [4:0]  gRw;
        logic [31:0] gBus;
        wrExp_t      e;
        Resetn = rstn; AReq = aReq; ARW = aRw; ABusW = aBus;
        BReq = bReq; BRW = bRw; BBusW = bBus;
        #1;
        expA = rstn && aReq && (!bReq || !mPriB);
        expB = rstn && bReq && !expA;
        check("AGnt", 32'(AGnt), 32'(expA));
        check("BGnt", 32'(BGnt), 32'(expB));
        gRw  = expB ? bRw : aRw;
        gBus = expB ? bBus : aBus;
        if (!rstn) begin
            mPriB = 1'b0; mCnt = '0; lastRw = '0; lastBus = '0;
            expQ.delete();
        end else begin
            if (mCurWr) mCnt++;
            if (expA || expB) begin
                mPriB   = expA;
                lastRw  = gRw;
                lastBus = gBus;
                if (!(FilterZero && gRw == 5'd0)) begin
                    e.rw = gRw; e.data = gBus;
                    expQ.push_back(e);
                end
            end
        end
        mCurWr = 1'b0;
        @(posedge Clk);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            mCurWr = 1'b1;
            check("RegWr", 32'(RegWr), 32'd1);
            check("RW",    32'(RW), 32'(e.rw));
            check("BusW",  BusW, e.data);
            check("Busy",  Busy, 32'd1 << e.rw);
        end else begin
            check("RegWr", 32'(RegWr), 32'd0);
            check("RWhold", 32'(RW), 32'(lastRw));
            check("BusWhold", BusW, lastBus);
            check("Busy",  Busy, 32'd0);
        end
        check("WrCnt", 32'(WrCnt), 32'(mCnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic doReset();
        step(1'b0, 1'b1, 5'd3, 32'hDEAD, 1'b1, 5'd4, 32'hBEEF);
    endtask

    initial begin
        Resetn = 1'b0; AReq = 1'b0; BReq = 1'b0;
        ARW = '0; BRW = '0; ABusW = '0; BBusW = '0;

        // Reset with requests asserted: no grants, outputs cleared.
        doReset();
        doReset();

        // Single A write then counter catch-up.
        step(1'b1, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0);
        check("busy030", Busy, 32'h00000020);
        check("cnt030a", 32'(WrCnt), 32'd0);
        idle(1);
        check("cnt030b", 32'(WrCnt), 32'd1);

        // Both requesting for 4 cycles alternate A,B,A,B with no bubble.
        doReset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 5'd1, 32'hA000_0000 + 32'(i), 1'b1, 5'd2, 32'hB000_0000 + 32'(i));
        idle(2);
        check("cnt031", 32'(WrCnt), 32'd4);

        // Write to register 0.
        doReset();
        step(1'b1, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'd0);
        check("regwr032", 32'(RegWr), FilterZero ? 32'd0 : 32'd1);
        idle(1);
        check("cnt032", 32'(WrCnt), FilterZero ? 32'd0 : 32'd1);

        // Reset right after a B grant at PRI_B: pointer returns to A.
        doReset();
        step(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("cnt033", 32'(WrCnt), 32'd0);
        check("rf9", rf[9], 32'h99);
        step(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB);
        check("afirst033", 32'(RW), 32'd10);
        idle(2);

        // Same destination from both: later write lands last.
        doReset();
        step(1'b1, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        step(1'b1, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        idle(2);
        check("rf7", rf[7], 32'hB);

        // Request withdrawn before the edge is not accepted.
        AReq = 1'b1; ARW = 5'd12; ABusW = 32'h55;
        #1;
        check("gntEarly", 32'(AGnt), 32'd1);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 60; i++)
            step(1'b1, 1'($urandom_range(1)), 5'($urandom), $urandom,
                 1'($urandom_range(1)), 5'($urandom), $urandom);
        idle(2);

        // Counter wrap after 65536 writes.
        doReset();
        for (int i = 0; i < 65536; i++) step(1'b1, 1'b1, 5'd3, 32'(i), 1'b0, 5'd0, 32'd0);
        check("cntFFFF", 32'(WrCnt), 32'h0000FFFF);
        idle(1);
        check("cntWrap", 32'(WrCnt), 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end
endmodule
